// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and data requesters
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state;
  logic              last_d;
  logic              own_d;
  logic [7:0]        cnt;
  logic              pick_d;
  logic              rsp_wr;
  logic              rsp_rd;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;
  // grant the non-last requester on a tie; response fires on write accept, read return or timeout
  always_comb begin
    pick_d   = d_req && (!if_req || !last_d);
    if_gnt   = state == IDLE && !rst && if_req && !pick_d;
    d_gnt    = state == IDLE && !rst && pick_d;
    rsp_wr   = state == ISSUE && mem_ready && mem_we;
    rsp_rd   = state == WAIT && (mem_rvalid || cnt == 8'(TIMEOUT - 1));
    rsp_err  = rsp_rd && !mem_rvalid;
    rsp_data = rsp_rd && mem_rvalid ? mem_rdata : '0;
  end
  // single-outstanding transaction FSM with registered memory command and responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_d       <= 1'b1;
      own_d        <= 1'b0;
      cnt          <= '0;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
    end else begin
      if_rsp_valid <= rsp_wr || rsp_rd ? !own_d : 1'b0;
      d_rsp_valid  <= rsp_wr || rsp_rd ? own_d : 1'b0;
      if ((rsp_wr || rsp_rd) && !own_d) begin
        if_rdata <= rsp_data;
        if_err   <= rsp_err;
      end
      if ((rsp_wr || rsp_rd) && own_d) begin
        d_rdata <= rsp_data;
        d_err   <= rsp_err;
      end
      case (state)
        IDLE: if (if_gnt || d_gnt) begin
          state     <= ISSUE;
          own_d     <= d_gnt;
          last_d    <= d_gnt;
          mem_valid <= 1'b1;
          mem_we    <= d_gnt && d_we;
          mem_be    <= d_gnt ? d_be : 4'hF;
          mem_addr  <= d_gnt ? d_addr : if_addr;
          mem_wdata <= d_gnt ? d_wdata : '0;
        end
        ISSUE: if (mem_ready) begin
          mem_valid <= 1'b0;
          cnt       <= '0;
          state     <= mem_we ? IDLE : WAIT;
        end
        WAIT: begin
          state <= rsp_rd ? IDLE : WAIT;
          cnt   <= rsp_rd ? cnt : cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_rsp_valid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic d_req, d_we, d_gnt, d_rsp_valid, d_err;
  logic [3:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [3:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // transaction-level model: one in-flight request, who owns it, how long it has waited
  bit men = 0;
  int last = 1;
  bit act = 0;
  bit acc = 0;
  int own = 0;
  int waited = 0;
  logic mwe = 0;
  logic [3:0] mbe = 0;
  logic [AW-1:0] maddr = 0;
  logic [DW-1:0] mwdata = 0;
  logic rv [2] = '{0, 0};
  logic [DW-1:0] rd [2] = '{0, 0};
  logic er [2] = '{0, 0};
  bit free;
  int win;
  logic eig, edg;

  always @(negedge clk) if (men) begin
    free = !act && !rst;
    win = (if_req && d_req) ? 1 - last : (d_req ? 1 : 0);
    eig = free && if_req && win == 0;
    edg = free && d_req && win == 1;
    chk("if_gnt", if_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    chk("mem_valid", mem_valid, act && !acc);
    if (act && !acc) begin
      chk("mem_we", mem_we, mwe);
      chk("mem_be", mem_be, mbe);
      chk("mem_addr", mem_addr, maddr);
      chk("mem_wdata", mem_wdata, mwdata);
    end
    chk("if_rsp_valid", if_rsp_valid, rv[0]);
    chk("if_rdata", if_rdata, rd[0]);
    chk("if_err", if_err, er[0]);
    chk("d_rsp_valid", d_rsp_valid, rv[1]);
    chk("d_rdata", d_rdata, rd[1]);
    chk("d_err", d_err, er[1]);
    if (rst) begin
      act = 0; last = 1; mwe = 0; mbe = 0; maddr = 0; mwdata = 0;
      for (int i = 0; i < 2; i++) begin rv[i] = 0; rd[i] = 0; er[i] = 0; end
    end else begin
      rv[0] = 0;
      rv[1] = 0;
      if (!act) begin
        if (eig || edg) begin
          act = 1; acc = 0; own = edg ? 1 : 0; last = own;
          mwe = edg && d_we;
          mbe = edg ? d_be : 4'hF;
          maddr = edg ? d_addr : if_addr;
          mwdata = edg ? d_wdata : '0;
        end
      end else if (!acc) begin
        if (mem_ready) begin
          if (mwe) begin act = 0; rv[own] = 1; rd[own] = 0; er[own] = 0; end
          else begin acc = 1; waited = 0; end
        end
      end else if (mem_rvalid) begin
        act = 0; rv[own] = 1; rd[own] = mem_rdata; er[own] = 0;
      end else if (waited == TO - 1) begin
        act = 0; rv[own] = 1; rd[own] = 0; er[own] = 1;
      end else waited++;
    end
  end

  logic gi, gd;
  int ord [4];
  int n, k;

  initial begin
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    tick();
    men = 1;
    if_req = 1;
    @(negedge clk);
    chk("gnt_in_rst", if_gnt, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    tick();
    // fetch read at 0x100 with one-cycle read return
    rst = 0; if_addr = 32'h100; mem_ready = 1;
    @(negedge clk); chk("c0_if_gnt", if_gnt, 1);
    tick(); if_req = 0;
    @(negedge clk); chk("c1_mem_valid", mem_valid, 1); chk("c1_mem_addr", mem_addr, 32'h100);
    chk("c1_mem_be", mem_be, 4'hF);
    tick(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("c2_if_rsp_valid", if_rsp_valid, 0);
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("c3_if_rsp_valid", if_rsp_valid, 1); chk("c3_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("c3_if_err", if_err, 0);
    tick();
    // both requesters held from reset alternate fetch, data, fetch, data
    rst = 1; if_req = 1; d_req = 1; d_we = 1; d_be = 4'hC; d_addr = 32'h80; d_wdata = 32'h77;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h11;
    tick(); rst = 0;
    n = 0; k = 0;
    while (n < 4 && k < 40) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin ord[n] = d_gnt ? 1 : 0; n++; end
      tick(); k++;
    end
    if_req = 0; d_req = 0;
    chk("rr_grants", n, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", ord[i], i % 2);
    repeat (6) tick();
    mem_ready = 0; mem_rvalid = 0;
    // data write held off by memory for three cycles
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234;
    @(negedge clk); chk("wr_d_gnt", d_gnt, 1);
    tick(); d_req = 0; d_addr = 32'hFFFF; d_wdata = 0; d_be = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      @(negedge clk);
      chk("wr_mem_valid", mem_valid, 1); chk("wr_mem_addr", mem_addr, 32'h40);
      chk("wr_mem_be", mem_be, 4'b0011); chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_wdata", mem_wdata, 32'h1234); chk("wr_d_rsp_early", d_rsp_valid, 0);
      tick();
    end
    mem_ready = 0;
    @(negedge clk); chk("wr_d_rsp_valid", d_rsp_valid, 1); chk("wr_d_err", d_err, 0);
    chk("wr_mem_valid_off", mem_valid, 0);
    tick();
    // read that never returns times out; a later stray return is ignored
    if_req = 1; if_addr = 32'h200; mem_ready = 1;
    @(negedge clk); chk("to_if_gnt", if_gnt, 1);
    tick(); if_req = 0;
    tick(); mem_ready = 0;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (if_rsp_valid) break;
      tick(); k++;
    end
    chk("to_latency", k, 16); chk("to_if_err", if_err, 1); chk("to_if_rdata", if_rdata, 0);
    tick(); mem_rvalid = 1; mem_rdata = 32'h55;
    repeat (2) begin
      @(negedge clk);
      chk("stray_if_rsp", if_rsp_valid, 0); chk("stray_d_rsp", d_rsp_valid, 0);
      chk("stray_if_err", if_err, 1);
      tick();
    end
    mem_rvalid = 0;
    // reset while waiting abandons the read and restores fetch priority on a tie
    if_req = 1; if_addr = 32'h240; mem_ready = 1;
    @(negedge clk); chk("rw_if_gnt", if_gnt, 1);
    tick(); if_req = 0;
    tick(); mem_ready = 0;
    tick(); tick();
    rst = 1; if_req = 1; d_req = 1; d_we = 0; d_addr = 32'h44;
    @(negedge clk); chk("rw_if_gnt_rst", if_gnt, 0); chk("rw_d_gnt_rst", d_gnt, 0);
    tick(); rst = 0;
    @(negedge clk);
    chk("rw_mem_valid", mem_valid, 0); chk("rw_if_rsp", if_rsp_valid, 0);
    chk("rw_if_err", if_err, 0); chk("rw_tie_if", if_gnt, 1); chk("rw_tie_d", d_gnt, 0);
    tick(); if_req = 0; d_req = 0; mem_ready = 1; mem_rvalid = 1;
    repeat (4) tick();
    mem_ready = 0; mem_rvalid = 0;
    tick();
    // read return coinciding with the timeout cycle counts as a normal response
    if_req = 1; if_addr = 32'h300; mem_ready = 1;
    @(negedge clk); chk("co_if_gnt", if_gnt, 1);
    tick(); if_req = 0;
    tick(); mem_ready = 0;
    for (int i = 0; i < 15; i++) tick();
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    tick(); mem_rvalid = 0;
    @(negedge clk); chk("co_if_rsp", if_rsp_valid, 1); chk("co_if_err", if_err, 0);
    chk("co_if_rdata", if_rdata, 32'hCAFEF00D);
    tick();
    // randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); gi = if_gnt; gd = d_gnt;
      tick();
      rst = ($urandom % 300) == 0;
      if (!if_req || gi) begin if_req = ($urandom % 3) == 0; if_addr = $urandom; end
      if (!d_req || gd) begin
        d_req = ($urandom % 3) == 0; d_we = $urandom % 2; d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = ($urandom % 3) != 0;
      mem_rvalid = ($urandom % 6) == 0;
      mem_rdata = $urandom;
    end
    if_req = 0; d_req = 0; rst = 1;
    tick(); rst = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum read-wait cycles (legal range 2..255).
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port if_req  in  1  fetch read request.
REQ-007 SHALL have port if_addr  in  ADDR_W  fetch address.
REQ-008 SHALL have port if_gnt  out  1  fetch request accepted this cycle.
REQ-009 SHALL have port if_rsp_valid  out  1  fetch response pulse.
REQ-010 SHALL have port if_rdata  out  DATA_W  fetch read data.
REQ-011 SHALL have port if_err  out  1  fetch response is a timeout.
REQ-012 SHALL have port d_req  in  1  data request.
REQ-013 SHALL have port d_we  in  1  data write (1) or read (0).
REQ-014 SHALL have port d_be  in  4  data byte enables.
REQ-015 SHALL have port d_addr  in  ADDR_W  data address.
REQ-016 SHALL have port d_wdata  in  DATA_W  data write data.
REQ-017 SHALL have ports d_gnt, d_rsp_valid, d_rdata, d_err  out  1/1/DATA_W/1  with the same meaning as the fetch equivalents.
REQ-018 SHALL have ports mem_valid, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/4/ADDR_W/DATA_W  memory command.
REQ-019 SHALL have ports mem_ready, mem_rvalid, mem_rdata  in  1/1/DATA_W  memory command accept, read-return strobe and read data.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE and WAIT, with one outstanding transaction at most.
REQ-021 In IDLE with any request, SHALL pick a winner, assert that winner's gnt combinationally in the same cycle, latch its command (fetch: we=0, be=4'hF), record the owner, and go to ISSUE.
REQ-022 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not granted last wins; the last-grant register SHALL reset to "data" so the first tie goes to fetch.
REQ-023 Requesters SHALL hold req and command fields stable until gnt; gnt SHALL be 0 outside IDLE.
REQ-024 In ISSUE, SHALL drive mem_valid=1 with the latched fields, holding them until mem_ready.
REQ-025 ISSUE & mem_ready & write SHALL go to IDLE and pulse owner rsp_valid for 1 cycle on the next cycle, with rdata=0 and err=0.
REQ-026 ISSUE & mem_ready & read SHALL go to WAIT with the wait counter cleared to 0.
REQ-027 WAIT & mem_rvalid SHALL register mem_rdata to the owner's rdata, pulse owner rsp_valid 1 cycle later with err=0, and go to IDLE.
REQ-028 In WAIT without mem_rvalid, the counter SHALL increment each cycle; at count TIMEOUT-1 it SHALL pulse owner rsp_valid with err=1 and rdata=0, then go to IDLE.
REQ-029 If mem_rvalid and the timeout coincide, SHALL treat it as a normal response with err=0.
REQ-030 SHALL ignore mem_rvalid in IDLE and ISSUE, including late returns after a timeout.
REQ-031 rdata and err SHALL hold their value until the next response to the same requester; the non-owner's response outputs SHALL remain unchanged.
REQ-032 Responses SHALL have no backpressure; requesters always accept rsp_valid.
REQ-033 Minimum occupancy SHALL be 2 cycles per write (IDLE, ISSUE) and 3 per read (IDLE, ISSUE, WAIT with immediate rvalid); a new grant MAY coincide with a prior response pulse.

Reset
REQ-034 While rst=1 at an edge: state=IDLE, last-grant=data, counter=0; all rsp_valid, err, mem_valid, mem_we=0; rdata, mem_addr, mem_wdata=0; mem_be=0.
REQ-035 Reset mid-transaction SHALL abandon it with no response issued; mem_valid SHALL be 0 from the cycle after the reset edge.
REQ-036 gnt SHALL be 0 while rst=1.

Verification
REQ-037 Bench SHALL cover: fetch-only read, addr 0x100, mem_ready=1, rvalid 1 cycle later with rdata 0xDEADBEEF -> if_gnt in cycle 0, mem_valid in cycle 1, if_rsp_valid=1 with if_rdata=0xDEADBEEF in cycle 3.
REQ-038 Bench SHALL cover: if_req and d_req both held high from reset for 4 transactions -> grant order fetch, data, fetch, data.
REQ-039 Bench SHALL cover: data write addr 0x40, be 4'b0011, wdata 0x1234, mem_ready delayed 3 cycles -> mem_* stable for 4 cycles, then d_rsp_valid one cycle after acceptance with d_err=0.
REQ-040 Bench SHALL cover: a read with no mem_rvalid and TIMEOUT=16 -> owner rsp_valid with err=1 and rdata=0; a later stray mem_rvalid produces no response.
REQ-041 Bench SHALL cover: rst asserted in WAIT -> no rsp_valid; next cycle mem_valid=0 and state IDLE; the next tie grants fetch.
REQ-042 Bench SHALL cover: mem_rvalid in the same cycle as the timeout -> err=0 and rdata = mem_rdata.
